// File: rtl/programmable_delay_line.sv
// rtl/programmable_delay_line.sv - programmable delay line over a circular sample buffer
module programmable_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    localparam int DLY_W    = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [DLY_W-1:0] delay_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DLY_W-1:0] cur_delay
);

    localparam int PTR_W = $clog2(MAX_DELAY);

    logic [WIDTH-1:0] mem [MAX_DELAY];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_idx;
    logic [DLY_W-1:0] fill;
    logic [DLY_W-1:0] fill_inc;
    logic [DLY_W-1:0] eff_delay;
    logic [DLY_W:0]   rd_sum;
    logic [DLY_W:0]   rd_mod;
    logic             restart;
    logic             advance;
    logic             valid_next;

    // Map the requested delay into 1..MAX_DELAY
    always_comb begin
        eff_delay = delay_sel;
        if (delay_sel == '0) begin
            eff_delay = DLY_W'(1);
        end else if (delay_sel > DLY_W'(MAX_DELAY)) begin
            eff_delay = DLY_W'(MAX_DELAY);
        end
    end

    // Restart decode, fill bookkeeping and modulo read index (oldest needed sample is D-1 writes back)
    always_comb begin
        restart     = flush || (en && (eff_delay != cur_delay));
        advance     = en && !restart;
        fill_inc    = (fill == DLY_W'(MAX_DELAY)) ? fill : fill + 1'b1;
        valid_next  = (fill_inc >= cur_delay);
        wr_ptr_next = (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr + 1'b1;
        rd_sum      = (DLY_W+1)'(wr_ptr) + (DLY_W+1)'(MAX_DELAY)
                      - ((DLY_W+1)'(cur_delay) - 1'b1);
        rd_mod      = (rd_sum >= (DLY_W+1)'(MAX_DELAY)) ? rd_sum - (DLY_W+1)'(MAX_DELAY) : rd_sum;
        rd_idx      = PTR_W'(rd_mod);
    end

    // Sample storage is never reset; it is only read once the fill covers D samples
    always_ff @(posedge clk) begin
        if (advance) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Control and output registers; a restart cycle writes nothing and starts a fresh fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            cur_delay <= DLY_W'(1);
            wr_ptr    <= '0;
            fill      <= '0;
        end else if (restart) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            cur_delay <= eff_delay;
            wr_ptr    <= '0;
            fill      <= '0;
        end else if (en) begin
            cur_delay <= eff_delay;
            wr_ptr    <= wr_ptr_next;
            fill      <= fill_inc;
            out_valid <= valid_next;
            if (!valid_next) begin
                out_data <= '0;
            end else if (cur_delay == DLY_W'(1)) begin
                out_data <= in_data;
            end else begin
                out_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_programmable_delay_line.sv
// tb/tb_programmable_delay_line.sv - directed self-checking bench for programmable_delay_line
module tb_programmable_delay_line;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_en, a_flush;
    logic [4:0] a_sel;
    logic [7:0] a_in;
    logic [7:0] a_out;
    logic       a_valid;
    logic [4:0] a_cur;

    logic       b_en, b_flush;
    logic [3:0] b_sel;
    logic [7:0] b_in;
    logic [7:0] b_out;
    logic       b_valid;
    logic [3:0] b_cur;

    int checks = 0;
    int errors = 0;

    programmable_delay_line #(.WIDTH(8), .MAX_DELAY(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .flush(a_flush), .delay_sel(a_sel),
        .in_data(a_in), .out_data(a_out), .out_valid(a_valid), .cur_delay(a_cur)
    );

    programmable_delay_line #(.WIDTH(8), .MAX_DELAY(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .flush(b_flush), .delay_sel(b_sel),
        .in_data(b_in), .out_data(b_out), .out_valid(b_valid), .cur_delay(b_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] d);
        chk({tag, ".valid"}, 64'(a_valid), 64'(v));
        chk({tag, ".data"}, 64'(a_out), 64'(d));
    endtask

    initial begin
        logic       ev;
        logic [7:0] ed;
        int         n;

        rst_n = 1'b1;
        a_en = 0; a_flush = 0; a_sel = 5'd1; a_in = 0;
        b_en = 0; b_flush = 0; b_sel = 4'd1; b_in = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset.valid", 64'(a_valid), 64'd0);
        chk("reset.data", 64'(a_out), 64'd0);
        chk("reset.cur", 64'(a_cur), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // D=5 configured by flush, then counting stream
        a_flush = 1; a_sel = 5'd5;
        step();
        chk("cfg5.cur", 64'(a_cur), 64'd5);
        a_flush = 0; a_en = 1;
        for (int k = 1; k <= 12; k++) begin
            a_in = 8'(k);
            step();
            chk_a("d5", k >= 5, (k >= 5) ? 8'(k - 4) : 8'd0);
        end

        // Delay select mapping: 16, clamp of 20, then 0 -> 1
        a_sel = 5'd16; step();
        chk("sel16.cur", 64'(a_cur), 64'd16);
        chk("sel16.valid", 64'(a_valid), 64'd0);
        a_sel = 5'd20; step();
        chk("sel20.cur", 64'(a_cur), 64'd16);
        a_sel = 5'd0; step();
        chk("sel0.cur", 64'(a_cur), 64'd1);
        chk_a("sel0.restart", 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            a_in = 8'(8'h21 + k);
            step();
            chk_a("d1", 1'b1, 8'(8'h21 + k));
        end

        // D=4 with en toggling: same sequence, stretched
        a_sel = 5'd4; a_en = 1; step();
        chk("d4.cur", 64'(a_cur), 64'd4);
        ev = 0; ed = 0; n = 0;
        for (int j = 1; j <= 16; j++) begin
            if (j % 2 == 1) begin
                n++;
                a_en = 1; a_in = 8'(8'h40 + n);
                ev = (n >= 4);
                ed = (n >= 4) ? 8'(8'h40 + n - 3) : 8'd0;
            end else begin
                a_en = 0; a_in = 8'hEE;
            end
            step();
            chk_a("d4.toggle", ev, ed);
        end

        // D=3 valid, then change to 7
        a_en = 1; a_sel = 5'd3; step();
        for (int k = 1; k <= 4; k++) begin
            a_in = 8'(8'h50 + k);
            step();
            chk_a("d3", k >= 3, (k >= 3) ? 8'(8'h50 + k - 2) : 8'd0);
        end
        a_sel = 5'd7; a_in = 8'h99; step();
        chk_a("chg7", 1'b0, 8'd0);
        chk("chg7.cur", 64'(a_cur), 64'd7);
        for (int k = 1; k <= 8; k++) begin
            a_in = 8'(8'h60 + k);
            step();
            chk_a("d7", k >= 7, (k >= 7) ? 8'(8'h60 + k - 6) : 8'd0);
        end

        // Flush with en=0 mid-stream, then refill
        a_en = 0; a_flush = 1; a_in = 8'hAA; step();
        chk_a("flush", 1'b0, 8'd0);
        chk("flush.cur", 64'(a_cur), 64'd7);
        a_flush = 0; a_en = 1;
        for (int k = 1; k <= 7; k++) begin
            a_in = 8'(8'h70 + k);
            step();
            chk_a("refill7", k >= 7, (k >= 7) ? 8'h71 : 8'd0);
        end

        // Flush coinciding with a delay change: one restart only
        a_flush = 1; a_sel = 5'd2; a_in = 8'h33; step();
        chk("flushchg.cur", 64'(a_cur), 64'd2);
        chk_a("flushchg", 1'b0, 8'd0);
        a_flush = 0;
        a_in = 8'h81; step();
        chk_a("d2.first", 1'b0, 8'd0);
        a_in = 8'h82; step();
        chk_a("d2.second", 1'b1, 8'h81);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk_a("areset", 1'b0, 8'd0);
        chk("areset.cur", 64'(a_cur), 64'd1);
        #1 rst_n = 1'b1;
        a_sel = 5'd3; a_in = 8'h11; step();
        chk("post_reset.cur", 64'(a_cur), 64'd3);
        for (int k = 1; k <= 4; k++) begin
            a_in = 8'(8'h90 + k);
            step();
            chk_a("post_reset", k >= 3, (k >= 3) ? 8'(8'h90 + k - 2) : 8'd0);
        end
        a_en = 0;

        // MAX_DELAY=10, D=10, 40 cycles across pointer wrap
        b_flush = 1; b_sel = 4'd10; step();
        chk("b.cur", 64'(b_cur), 64'd10);
        b_flush = 0; b_en = 1;
        for (int k = 1; k <= 40; k++) begin
            b_in = 8'(k);
            step();
            chk("b.valid", 64'(b_valid), 64'(k >= 10));
            chk("b.data", 64'(b_out), (k >= 10) ? 64'(k - 9) : 64'd0);
        end
        b_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
